// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared constants, FSM state type and helper for the BCD
//            arithmetic datapath (serial subtractor and its digit add cell).
// Contents : DIGIT_W  - bits per packed-BCD digit
//            BCD_MAX  - largest legal BCD digit (also the nine's-complement base)
//            BCD_ADJ  - decimal correction added when a digit sum exceeds 9
//            state_t  - serial subtractor states
//            is_illegal_digit() - 1 for the non-decimal codes 10..15
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_illegal_digit(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Purpose  : Combinational one-digit BCD adder, s = BCD(a + b + cin).
// Ports    : a, b  (in, 4)  BCD digit operands
//            cin   (in, 1)  carry in
//            s     (out, 4) corrected BCD sum digit
//            cout  (out, 1) decimal carry out
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] w_raw;
  logic       w_corr;

  always_comb begin
    w_raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // A binary carry (sum >= 16) also needs the +6 correction, since the
    // low nibble then no longer reflects the decimal overflow.
    w_corr = w_raw[4] | (w_raw[3:0] > BCD_MAX);
    s      = w_corr ? (w_raw[3:0] + BCD_ADJ) : w_raw[3:0];
    cout   = w_corr;
  end

endmodule
`default_nettype wire

// File: rtl/bcd_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sub_serial
// Purpose  : Digit-serial packed-BCD subtractor producing |A - B| and a sign
//            flag, one digit per clock, least significant digit first.
//            A - B is formed as A + ten's complement of B; a missing final
//            carry means the result is negative, and a second pass replaces
//            the stored result with its ten's complement to give magnitude.
// Ports    : clk          (in)  clock, rising edge
//            reset        (in)  synchronous active-high reset
//            start        (in)  request pulse, only honoured in IDLE
//            A, B         (in)  minuend / subtrahend, packed BCD
//            busy         (out) high in SUB, COMP and DONE
//            done         (out) one-cycle result-valid pulse
//            diff         (out) magnitude |A - B|, packed BCD
//            negative     (out) 1 when A < B
//            out_of_range (out) 1 when a latched operand digit was > 9
// Revision : 1.0 - initial release
// ============================================================================
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
)
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] A,
  input  logic [DIGIT_W*NDIGITS-1:0] B,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*NDIGITS-1:0] diff,
  output logic                       negative,
  output logic                       out_of_range
);

  localparam int DW   = DIGIT_W * NDIGITS;
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_diff;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_neg;
  logic            r_oor;

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_d_dig;
  logic [3:0]      w_op_a;
  logic [3:0]      w_op_b;
  logic [3:0]      w_sum;
  logic            w_cout;
  logic            w_last;
  logic            w_in_illegal;

  // Legality is judged on the values captured at the accepting edge.
  always_comb begin
    w_in_illegal = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (is_illegal_digit(A[i*DIGIT_W +: DIGIT_W]) ||
          is_illegal_digit(B[i*DIGIT_W +: DIGIT_W]))
        w_in_illegal = 1'b1;
    end
  end

  // Current digit of each latched register.
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    w_d_dig = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_dig = r_a[i*DIGIT_W +: DIGIT_W];
        w_b_dig = r_b[i*DIGIT_W +: DIGIT_W];
        w_d_dig = r_diff[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // One add cell serves both passes: SUB adds A_i + (9 - B_i), COMP adds
  // (9 - diff_i) + 0; the carry register supplies the +1 of ten's complement.
  always_comb begin
    if (r_state == SUB) begin
      w_op_a = w_a_dig;
      w_op_b = BCD_MAX - w_b_dig;
    end else begin
      w_op_a = BCD_MAX - w_d_dig;
      w_op_b = '0;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (w_op_a),
    .b    (w_op_b),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  assign w_last = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = w_in_illegal ? DONE : SUB;
      end
      SUB:  if (w_last) w_state_next = w_cout ? DONE : COMP;
      COMP: if (w_last) w_state_next = DONE;
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_diff  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b1;
            r_neg   <= 1'b0;
            r_oor   <= w_in_illegal;
          end
        end
        SUB, COMP: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (r_idx == IDXW'(i)) r_diff[i*DIGIT_W +: DIGIT_W] <= w_sum;
          end
          r_carry <= w_cout;
          if (!w_last) begin
            r_idx <= r_idx + IDXW'(1);
          end else if (r_state == SUB && !w_cout) begin
            // No carry out of the top digit: A < B, start the re-complement.
            r_neg   <= 1'b1;
            r_idx   <= '0;
            r_carry <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff         = r_diff;
  assign negative     = r_neg;
  assign out_of_range = r_oor;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_sub_serial
// Purpose  : Directed self-checking bench for bcd_sub_serial (NDIGITS = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_sub_serial;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        negative;
  logic        out_of_range;

  int n_asserts;
  int n_fails;

  bcd_sub_serial #(.NDIGITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .A            (A),
    .B            (B),
    .busy         (busy),
    .done         (done),
    .diff         (diff),
    .negative     (negative),
    .out_of_range (out_of_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, then follow it to done, checking latency (in cycles
  // after the accepting edge), busy duration and the results.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input int lat, input logic [15:0] exp_diff,
                       input logic exp_neg, input logic exp_oor);
    int n;
    int busy_cnt;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'hFFFF; B = 16'h0AAA;   // operands are latched; these must not matter
    n = 1; busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (done) busy_cnt++;
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_cycles"}, busy_cnt, lat);
    chk({tag, "_diff"}, {16'h0, diff}, {16'h0, exp_diff});
    chk({tag, "_negative"}, {31'h0, negative}, {31'h0, exp_neg});
    chk({tag, "_oor"}, {31'h0, out_of_range}, {31'h0, exp_oor});
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {30'h0, busy, done}, 32'h0);
    chk({tag, "_diff_hold"}, {16'h0, diff}, {16'h0, exp_diff});
  endtask

  initial begin
    int n;
    int done_cnt;
    n_asserts = 0;
    n_fails   = 0;
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, negative, out_of_range, diff}, 20'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, negative, out_of_range, diff}, 20'h0);

    do_op("pos_5000_1234", 16'h5000, 16'h1234, 5, 16'h3766, 1'b0, 1'b0);
    do_op("neg_1234_5000", 16'h1234, 16'h5000, 9, 16'h3766, 1'b1, 1'b0);
    do_op("wrap_0000_9999", 16'h0000, 16'h9999, 9, 16'h9999, 1'b1, 1'b0);
    do_op("equal_4321", 16'h4321, 16'h4321, 5, 16'h0000, 1'b0, 1'b0);
    do_op("illegal_00A5", 16'h00A5, 16'h0001, 1, 16'h0000, 1'b0, 1'b1);
    do_op("after_illegal", 16'h0010, 16'h0001, 5, 16'h0009, 1'b0, 1'b0);
    do_op("max_9999_0000", 16'h9999, 16'h0000, 5, 16'h9999, 1'b0, 1'b0);
    do_op("neg_0001_0002", 16'h0001, 16'h0002, 9, 16'h0001, 1'b1, 1'b0);

    // start re-pulsed during SUB with other operands must be ignored.
    @(negedge clk);
    A = 16'h5000; B = 16'h1234; start = 1'b1;
    @(negedge clk);                         // first SUB cycle
    A = 16'h1111; B = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_start_latency", n, 5);
    chk("ignore_start_diff", {16'h0, diff}, 32'h3766);
    chk("ignore_start_neg", {31'h0, negative}, 32'h0);
    @(negedge clk);
    chk("ignore_start_idle", {31'h0, busy}, 32'h0);

    // Reset in the second SUB cycle aborts the operation without a done.
    @(negedge clk);
    A = 16'h1234; B = 16'h5000; start = 1'b1;
    @(negedge clk);                         // SUB, digit 0
    start = 1'b0;
    @(negedge clk);                         // SUB, digit 1
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {busy, done, negative, out_of_range, diff}, 20'h0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    do_op("after_abort", 16'h1234, 16'h5000, 9, 16'h3766, 1'b1, 1'b0);

    // reset and start together: reset wins.
    @(negedge clk);
    A = 16'h5000; B = 16'h1234; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("reset_beats_start", {busy, done, diff}, 18'h0);
    @(negedge clk);
    chk("reset_beats_start_idle", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
- Multi-digit BCD subtractor; the complement direction of the team's combinational BCD adder.
- Computes |A - B| plus a sign flag for NDIGITS-digit packed-BCD operands, digit-serial, one digit per clock, LSD first.
- Uses ten's-complement addition through a one-digit BCD add cell; re-complements the result when negative.
- Sits beside the adder in the BCD arithmetic datapath, driven by a start/done handshake.

Parameters:
- NDIGITS, 4, number of BCD digits per operand (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  4*NDIGITS  minuend, packed BCD, digit 0 = bits [3:0].
- B  input  4*NDIGITS  subtrahend, packed BCD.
- busy  output  1  high in SUB, COMP, DONE.
- done  output  1  one-cycle pulse when results are valid.
- diff  output  4*NDIGITS  magnitude |A-B|, packed BCD.
- negative  output  1  1 when A < B.
- out_of_range  output  1  1 when any digit of A or B latched at start is > 9.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, busy=0, done=0, diff=0, negative=0, out_of_range=0, internal regs 0.
- States: IDLE, SUB, COMP, DONE.
- IDLE:
  - On start=1 at edge k, latch A and B into operand regs and compute out_of_range from latched digits.
  - Illegal input: diff=0, negative=0, go to DONE at k+1.
  - Legal input: clear digit index and diff, set carry=1, out_of_range=0, go to SUB.
- SUB, digit index i = 0..NDIGITS-1, one digit per cycle:
  - d_i = BCD(A_i + (9 - B_i) + carry).
  - carry = BCD carry-out (sum > 9). Store d_i in diff[4i+3:4i].
  - After the digit NDIGITS-1 cycle:
    - carry=1: A >= B, negative=0, go to DONE.
    - carry=0: A < B, negative=1, reset index, carry=1, go to COMP.
- COMP, i = 0..NDIGITS-1:
  - diff_i = BCD((9 - diff_i) + 0 + carry), i.e. the ten's complement of the stored result.
  - After the last digit, go to DONE.
  - The final carry is discarded.
- DONE: done=1 for exactly this cycle, busy=1, then IDLE.
- Latency from the start edge k, with done high in the given cycle:
  - illegal input: k+1.
  - A >= B: k+NDIGITS+1.
  - A < B: k+2*NDIGITS+1.
- diff, negative, out_of_range hold their values after DONE until the next accepted start. diff is cleared at acceptance.
- start is ignored while busy=1. No queuing.
- A and B may change freely after acceptance; only the latched copies are used.
- A == B gives diff=0, negative=0, with no "-0".
- Wrap case 0 - 10^N-1 (e.g. 0000-9999): diff=9999, negative=1.
- Reset mid-operation: abort next edge, all outputs return to reset values, and done is never pulsed for the aborted op.
- reset and start in the same cycle: reset wins.
- Digit add cell correction: add 6 when raw sum > 9 or the binary carry is set. Cell carry-out = correction condition.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9, BCD_ADJ=4'd6.
  - state enum {IDLE, SUB, COMP, DONE}.
  - function is_illegal_digit.
- One combinational sub-module, bcd_digit_add:
  - inputs a[3:0], b[3:0], cin.
  - outputs s[3:0], cout.
  - instantiated once and shared by SUB and COMP through an operand mux.
- Index counter width $clog2(NDIGITS) (min 1).

Test Plan:
- A=16'h5000, B=16'h1234, start one cycle -> done at start+5, diff=16'h3766, negative=0, out_of_range=0, busy high for 5 cycles.
- A=16'h1234, B=16'h5000 -> done at start+9, diff=16'h3766, negative=1.
- A=16'h0000, B=16'h9999 -> diff=16'h9999, negative=1. A=B=16'h4321 -> diff=16'h0000, negative=0, done at start+5.
- A=16'h00A5, B=16'h0001 -> done at start+1, out_of_range=1, diff=0, negative=0. Next start with A=16'h0010, B=16'h0001 -> out_of_range=0, diff=16'h0009.
- start re-pulsed during SUB with different operands -> ignored, first result unchanged. reset asserted in the 2nd SUB cycle -> next cycle busy=0, diff=0, no done pulse. A new start afterwards completes normally.
